// File: rtl/alu_issue.sv
// Issue/decode front end for a combinational MIPS-style ALU: accepts one instruction,
// drives the ALU for one execute cycle, then returns the captured result on a response handshake.
module alu_issue #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  output logic [5:0]       aluc,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_r,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_negative,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_rd,
  output logic             out_wr_en,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_negative,
  output logic             out_trap,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] trap_count
);

  // state | meaning
  // IDLE  | waiting for an instruction, in_ready high
  // EXEC  | decoded opcode/operands driven to the ALU for one cycle
  // RESP  | captured result presented until out_ready
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [5:0] ALUC_IDLE = 6'b100001;

  state_t r_state, w_state_nxt;

  logic [5:0]       r_aluc;
  logic [31:0]      r_alu_a, r_alu_b;
  logic [4:0]       r_rd;
  logic             r_illegal, r_trapable;
  logic             r_out_valid, r_out_wr_en, r_out_zero, r_out_carry;
  logic             r_out_negative, r_out_trap, r_out_illegal;
  logic [31:0]      r_out_result;
  logic [4:0]       r_out_rd;
  logic [CNT_W-1:0] r_op_count, r_trap_count;

  logic        w_accept, w_resp_hs, w_trap;
  logic [5:0]  w_opcode, w_funct;
  logic [15:0] w_imm;
  logic [5:0]  w_dec_aluc;
  logic [31:0] w_dec_a, w_dec_b;
  logic [4:0]  w_dec_rd;
  logic        w_dec_illegal, w_dec_trapable;

  assign w_accept  = in_valid & (r_state == S_IDLE);
  assign w_resp_hs = r_out_valid & out_ready;
  assign w_opcode  = instr[31:26];
  assign w_funct   = instr[5:0];
  assign w_imm     = instr[15:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (w_resp_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_dec_aluc     = ALUC_IDLE;
    w_dec_a        = 32'd0;
    w_dec_b        = 32'd0;
    w_dec_rd       = instr[20:16];
    w_dec_illegal  = 1'b0;
    w_dec_trapable = 1'b0;
    if (w_opcode == 6'b000000) begin
      w_dec_rd   = instr[15:11];
      w_dec_aluc = w_funct;
      case (w_funct)
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
          w_dec_a        = rs_val;
          w_dec_b        = rt_val;
          w_dec_trapable = (w_funct == 6'h20) || (w_funct == 6'h22);
        end
        6'h00, 6'h02, 6'h03: begin
          w_dec_a = rt_val;
          w_dec_b = {27'd0, instr[10:6]};
        end
        6'h04, 6'h06, 6'h07: begin
          w_dec_a = rt_val;
          w_dec_b = {27'd0, rs_val[4:0]};
        end
        default: begin
          w_dec_aluc    = ALUC_IDLE;
          w_dec_illegal = 1'b1;
        end
      endcase
    end else begin
      w_dec_a = rs_val;
      case (w_opcode)
        6'b001000: begin
          w_dec_aluc     = 6'b100000;
          w_dec_b        = {{16{w_imm[15]}}, w_imm};
          w_dec_trapable = 1'b1;
        end
        6'b001001: begin w_dec_aluc = 6'b100001; w_dec_b = {{16{w_imm[15]}}, w_imm}; end
        6'b001010: begin w_dec_aluc = 6'b101010; w_dec_b = {{16{w_imm[15]}}, w_imm}; end
        6'b001011: begin w_dec_aluc = 6'b101011; w_dec_b = {{16{w_imm[15]}}, w_imm}; end
        6'b001100: begin w_dec_aluc = 6'b100100; w_dec_b = {16'd0, w_imm}; end
        6'b001101: begin w_dec_aluc = 6'b100101; w_dec_b = {16'd0, w_imm}; end
        6'b001110: begin w_dec_aluc = 6'b100110; w_dec_b = {16'd0, w_imm}; end
        6'b001111: begin w_dec_aluc = 6'b001111; w_dec_a = {16'd0, w_imm}; end
        default: begin
          w_dec_a       = 32'd0;
          w_dec_illegal = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  assign w_trap = r_trapable & alu_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aluc         <= ALUC_IDLE;
      r_alu_a        <= 32'd0;
      r_alu_b        <= 32'd0;
      r_rd           <= 5'd0;
      r_illegal      <= 1'b0;
      r_trapable     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_result   <= 32'd0;
      r_out_rd       <= 5'd0;
      r_out_wr_en    <= 1'b0;
      r_out_zero     <= 1'b0;
      r_out_carry    <= 1'b0;
      r_out_negative <= 1'b0;
      r_out_trap     <= 1'b0;
      r_out_illegal  <= 1'b0;
      r_op_count     <= '0;
      r_trap_count   <= '0;
    end else if (w_accept) begin
      r_aluc     <= w_dec_aluc;
      r_alu_a    <= w_dec_a;
      r_alu_b    <= w_dec_b;
      r_rd       <= w_dec_rd;
      r_illegal  <= w_dec_illegal;
      r_trapable <= w_dec_trapable;
    end else if (r_state == S_EXEC) begin
      // ALU operands drop back to idle values as the result is captured
      r_aluc         <= ALUC_IDLE;
      r_alu_a        <= 32'd0;
      r_alu_b        <= 32'd0;
      r_out_valid    <= 1'b1;
      r_out_result   <= r_illegal ? 32'd0 : alu_r;
      r_out_rd       <= r_rd;
      r_out_wr_en    <= !r_illegal && !w_trap && (r_rd != 5'd0);
      r_out_zero     <= alu_zero;
      r_out_carry    <= alu_carry;
      r_out_negative <= alu_negative;
      r_out_trap     <= w_trap;
      r_out_illegal  <= r_illegal;
    end else if (w_resp_hs) begin
      r_out_valid <= 1'b0;
      r_op_count  <= r_op_count + 1'b1;
      if ((r_out_trap || r_out_illegal) && (r_trap_count != {CNT_W{1'b1}}))
        r_trap_count <= r_trap_count + 1'b1;
    end
  end

  assign in_ready     = (r_state == S_IDLE);
  assign aluc         = r_aluc;
  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign out_valid    = r_out_valid;
  assign out_result   = r_out_result;
  assign out_rd       = r_out_rd;
  assign out_wr_en    = r_out_wr_en;
  assign out_zero     = r_out_zero;
  assign out_carry    = r_out_carry;
  assign out_negative = r_out_negative;
  assign out_trap     = r_out_trap;
  assign out_illegal  = r_out_illegal;
  assign op_count     = r_op_count;
  assign trap_count   = r_trap_count;

endmodule
